// File: rtl/sdram_frame_sched.sv
// sdram_frame_sched: request sequencer between the ROM-fill FIFO, the VGA read
// FIFO and sdram_top, running in the 133 MHz SDRAM domain.
//
// A single FSM issues at most one outstanding burst request at a time:
//   - write phase: loads one frame as ROWS full-row bursts, each issued once the
//     write FIFO holds at least WR_THRESH words;
//   - read phase: once per video frame, streams the stored rows back while VSYNC
//     is high and the read FIFO has drained to RD_LOW_WM or below.
//
// Optional feature macro: SCHED_UNDERRUN_CNT_EN
//   When defined, adds underrun_cnt_o, a saturating count of VSYNC falling edges
//   that arrive before the loaded frame has been fully streamed.
module sdram_frame_sched #(
  parameter int         ROWS      = 128,
  parameter int         WR_THRESH = 512,
  parameter int         RD_LOW_WM = 512,
  parameter logic [1:0] BANK      = 2'd0
) (
  input  logic        clk_133M_i,
  input  logic        rst_133i,
  input  logic        vsync_i,
  input  logic [10:0] wr_fifo_used_i,
  input  logic [10:0] rd_fifo_used_i,
  output logic        wr_sdram_req_o,
  input  logic        wr_sdram_ack_i,
  output logic [23:0] wr_sdram_add_o,
  output logic        rd_sdram_req_o,
  input  logic        rd_sdram_ack_i,
  output logic [23:0] rd_sdram_add_o,
  output logic        frame_loaded_o,
  output logic        rd_frame_done_o,
  output logic        busy_o
`ifdef SCHED_UNDERRUN_CNT_EN
  ,
  output logic [7:0]  underrun_cnt_o
`endif
);

  localparam int         ROW_W        = 13;
  localparam logic [12:0] ROWS_C      = 13'(ROWS);
  localparam logic [10:0] WR_THRESH_C = 11'(WR_THRESH);
  localparam logic [10:0] RD_LOW_WM_C = 11'(RD_LOW_WM);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_REQ = 2'd1,
    RD_REQ = 2'd2
  } state_t;

  state_t           state;
  logic [ROW_W-1:0] wr_row;
  logic [ROW_W-1:0] rd_row;
  logic             vs_p0;
  logic             vs_s;
  logic             rd_abort;
  logic             wr_ok;
  logic             rd_ok;

  // Row counters never wrap: they hold at ROWS once the frame is complete.
  function automatic logic [ROW_W-1:0] row_inc(input logic [ROW_W-1:0] r);
    if (r >= ROWS_C) begin
      return ROWS_C;
    end
    return r + 13'd1;
  endfunction

  // Stage p0 -> s: two-flop synchronizer for VSYNC from the 100 MHz domain.
  always_ff @(posedge clk_133M_i or posedge rst_133i) begin
    if (rst_133i) begin
      vs_p0 <= 1'b0;
      vs_s  <= 1'b0;
    end else begin
      vs_p0 <= vsync_i;
      vs_s  <= vs_p0;
    end
  end

  // Eligibility of the next burst; write takes priority when both are ready.
  always_comb begin
    wr_ok = (wr_row < ROWS_C) && (wr_fifo_used_i >= WR_THRESH_C);
    rd_ok = frame_loaded_o && vs_s && (rd_row < ROWS_C) &&
            (rd_fifo_used_i <= RD_LOW_WM_C);
  end

  // Request FSM: registered req/busy, row counters and frame status flags.
  always_ff @(posedge clk_133M_i or posedge rst_133i) begin
    if (rst_133i) begin
      state           <= IDLE;
      wr_sdram_req_o  <= 1'b0;
      rd_sdram_req_o  <= 1'b0;
      busy_o          <= 1'b0;
      frame_loaded_o  <= 1'b0;
      rd_frame_done_o <= 1'b0;
      wr_row          <= '0;
      rd_row          <= '0;
      rd_abort        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Retrace: rewind the read side so the next frame starts at row 0.
          if (!vs_s) begin
            rd_row          <= '0;
            rd_frame_done_o <= 1'b0;
          end
          if (wr_ok) begin
            state          <= WR_REQ;
            wr_sdram_req_o <= 1'b1;
            busy_o         <= 1'b1;
          end else if (rd_ok) begin
            state          <= RD_REQ;
            rd_sdram_req_o <= 1'b1;
            busy_o         <= 1'b1;
            rd_abort       <= 1'b0;
          end
        end

        WR_REQ: begin
          if (wr_sdram_ack_i) begin
            state          <= IDLE;
            wr_sdram_req_o <= 1'b0;
            busy_o         <= 1'b0;
            wr_row         <= row_inc(wr_row);
            if (row_inc(wr_row) == ROWS_C) begin
              frame_loaded_o <= 1'b1;
            end
          end
        end

        RD_REQ: begin
          // A retrace seen during the burst voids it; remember that until ack.
          if (!vs_s) begin
            rd_abort <= 1'b1;
          end
          if (rd_sdram_ack_i) begin
            state          <= IDLE;
            rd_sdram_req_o <= 1'b0;
            busy_o         <= 1'b0;
            if (rd_abort || !vs_s) begin
              rd_row          <= '0;
              rd_frame_done_o <= 1'b0;
            end else begin
              rd_row          <= row_inc(rd_row);
              rd_frame_done_o <= (row_inc(rd_row) == ROWS_C);
            end
          end
        end

        default: begin
          state          <= IDLE;
          wr_sdram_req_o <= 1'b0;
          rd_sdram_req_o <= 1'b0;
          busy_o         <= 1'b0;
        end
      endcase
    end
  end

  assign wr_sdram_add_o = {BANK, wr_row, 9'd0};
  assign rd_sdram_add_o = {BANK, rd_row, 9'd0};

`ifdef SCHED_UNDERRUN_CNT_EN
  logic vs_d;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end
    return v + 8'd1;
  endfunction

  // Count retraces that arrive before the loaded frame was fully streamed.
  always_ff @(posedge clk_133M_i or posedge rst_133i) begin
    if (rst_133i) begin
      vs_d           <= 1'b0;
      underrun_cnt_o <= 8'd0;
    end else begin
      vs_d <= vs_s;
      if (vs_d && !vs_s && frame_loaded_o && (rd_row < ROWS_C)) begin
        underrun_cnt_o <= sat_inc8(underrun_cnt_o);
      end
    end
  end
`endif

endmodule

// File: tb/tb_sdram_frame_sched.sv
// Scoreboard bench for sdram_frame_sched: expected burst rows are queued when a
// phase is started, a monitor pops them on every request rise, and a responder
// acknowledges bursts after random delays and injects stray acks.
module tb_sdram_frame_sched;

  localparam int ROWS = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vsync = 1'b1;
  logic [10:0] wr_used = 11'd0;
  logic [10:0] rd_used = 11'd1000;
  logic        wr_req;
  logic        wr_ack = 1'b0;
  logic [23:0] wr_add;
  logic        rd_req;
  logic        rd_ack = 1'b0;
  logic [23:0] rd_add;
  logic        frame_loaded;
  logic        rd_frame_done;
  logic        busy;
`ifdef SCHED_UNDERRUN_CNT_EN
  logic [7:0]  underrun_cnt;
`endif

  int checks = 0;
  int passed = 0;
  int wr_q[$];
  int rd_q[$];
  int wr_done = 0;
  int rd_done = 0;
  int wr_rises = 0;
  bit wr_hold = 1'b0;
  int rd_limit = 1 << 30;

  sdram_frame_sched dut (
    .clk_133M_i     (clk),
    .rst_133i       (rst),
    .vsync_i        (vsync),
    .wr_fifo_used_i (wr_used),
    .rd_fifo_used_i (rd_used),
    .wr_sdram_req_o (wr_req),
    .wr_sdram_ack_i (wr_ack),
    .wr_sdram_add_o (wr_add),
    .rd_sdram_req_o (rd_req),
    .rd_sdram_ack_i (rd_ack),
    .rd_sdram_add_o (rd_add),
    .frame_loaded_o (frame_loaded),
    .rd_frame_done_o(rd_frame_done),
    .busy_o         (busy)
`ifdef SCHED_UNDERRUN_CNT_EN
    ,
    .underrun_cnt_o (underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  // Row n of the frame lives at bank 0, row n, column 0.
  function automatic logic [23:0] exp_addr(int row);
    logic [12:0] r;
    r = row[12:0];
    return {2'b00, r, 9'd0};
  endfunction

  // Responder: acks each burst after 0..4 extra cycles, plus stray acks when idle.
  initial begin : responder
    int ww;
    int rw;
    bit wl;
    bit rl;
    ww = -1; rw = -1; wl = 1'b0; rl = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (wl) wr_done++;
      if (rl) rd_done++;
      wl = 1'b0; rl = 1'b0;
      wr_ack = 1'b0; rd_ack = 1'b0;
      if (rst) begin
        ww = -1; rw = -1; wr_done = 0;
      end else begin
        if (!wr_req) begin
          ww = -1;
          if ($urandom_range(0, 15) == 0) wr_ack = 1'b1;
        end else begin
          if (ww < 0) ww = $urandom_range(0, 4);
          if (ww > 0) ww--;
          else if (!wr_hold) begin wr_ack = 1'b1; wl = 1'b1; end
        end
        if (!rd_req) begin
          rw = -1;
          if ($urandom_range(0, 15) == 0) rd_ack = 1'b1;
        end else begin
          if (rw < 0) rw = $urandom_range(0, 4);
          if (rw > 0) rw--;
          else if (rd_done < rd_limit) begin rd_ack = 1'b1; rl = 1'b1; end
        end
      end
    end
  end

  // Monitor: each request rise must be expected and carry the queued row.
  initial begin : monitor
    bit pw;
    bit pr;
    bit fl_exp_prev;
    bit fl_dut_prev;
    bit fl_exp;
    int r;
    pw = 1'b0; pr = 1'b0; fl_exp_prev = 1'b0; fl_dut_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        fl_exp_prev = 1'b0; fl_dut_prev = 1'b0;
      end else begin
        if (wr_req && !pw) begin
          wr_rises++;
          chk("wr_req_expected", 32'(wr_q.size() != 0), 32'd1);
          if (wr_q.size() != 0) begin
            r = wr_q.pop_front();
            chk("wr_addr", 32'(wr_add), 32'(exp_addr(r)));
          end
        end
        if (rd_req && !pr) begin
          chk("rd_req_expected", 32'(rd_q.size() != 0), 32'd1);
          if (rd_q.size() != 0) begin
            r = rd_q.pop_front();
            chk("rd_addr", 32'(rd_add), 32'(exp_addr(r)));
          end
        end
        fl_exp = (wr_done >= ROWS);
        if (fl_exp != fl_exp_prev || frame_loaded != fl_dut_prev)
          chk("frame_loaded_timing", 32'(frame_loaded), 32'(fl_exp));
        fl_exp_prev = fl_exp;
        fl_dut_prev = frame_loaded;
      end
      pw = wr_req;
      pr = rd_req;
    end
  end

  // Runs one full read frame with a randomly wandering read-FIFO level.
  task automatic read_frame(input string tag);
    int base;
    int t;
    base = rd_done;
    for (int i = 0; i < ROWS; i++) rd_q.push_back(i);
    t = 0;
    while ((rd_done - base) < ROWS && t < 8000) begin
      @(posedge clk); #1;
      rd_used = 11'($urandom_range(300, 700));
      t++;
    end
    @(negedge clk);
    chk({tag, "_frame_done"}, 32'(rd_frame_done), 32'd1);
    chk({tag, "_rd_queue_drained"}, 32'(rd_q.size()), 32'd0);
  endtask

  initial begin : main
    int t;
    int wr_base;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_req", 32'(wr_req), 32'd0);
    chk("rst_rd_req", 32'(rd_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_loaded", 32'(frame_loaded), 32'd0);
    chk("rst_rd_frame_done", 32'(rd_frame_done), 32'd0);
    chk("rst_wr_add", 32'(wr_add), 32'd0);
    chk("rst_rd_add", 32'(rd_add), 32'd0);
`ifdef SCHED_UNDERRUN_CNT_EN
    chk("rst_underrun", 32'(underrun_cnt), 32'd0);
`endif
    @(posedge clk); #1 rst = 1'b0;

    // Threshold edge: one word short issues nothing
    wr_used = 11'd511;
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("wr_req_below_thresh", 32'(wr_req), 32'd0);
    wr_hold = 1'b1;
    wr_q.push_back(0);
    @(posedge clk); #1 wr_used = 11'd512;
    t = 0;
    while (!wr_req && t < 4) begin @(negedge clk); t++; end
    chk("wr_req_at_thresh", 32'(wr_req), 32'd1);
    repeat (3) @(negedge clk);
    chk("wr_req_held_no_ack", 32'(wr_req), 32'd1);
    chk("busy_in_wr_req", 32'(busy), 32'd1);

    // Reset mid-handshake drops the request immediately
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("async_rst_wr_req", 32'(wr_req), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_frame_loaded", 32'(frame_loaded), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    wr_hold = 1'b0;
    wr_q.delete();
    for (int i = 0; i < ROWS; i++) wr_q.push_back(i);
    chk("wr_add_after_rst", 32'(wr_add), 32'(exp_addr(0)));

    // Fill load with a wandering write-FIFO level
    wr_base = wr_rises;
    t = 0;
    while (!frame_loaded && t < 5000) begin
      @(posedge clk); #1;
      wr_used = 11'($urandom_range(420, 700));
      t++;
    end
    chk("fill_completes", 32'(frame_loaded), 32'd1);
    wr_used = 11'd600;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("wr_burst_count", 32'(wr_rises - wr_base), 32'(ROWS));
    chk("wr_queue_drained", 32'(wr_q.size()), 32'd0);
    chk("no_wr_after_load", 32'(wr_req), 32'd0);
    chk("frame_loaded_sticky", 32'(frame_loaded), 32'd1);

    // Read gating on the low watermark
    @(posedge clk); #1 rd_used = 11'd513;
    repeat (50) @(posedge clk);
    @(negedge clk);
    chk("rd_req_above_wm", 32'(rd_req), 32'd0);
    rd_q.push_back(0);
    @(posedge clk); #1 rd_used = 11'd512;
    t = 0;
    while (!rd_req && t < 4) begin @(negedge clk); t++; end
    chk("rd_req_at_wm", 32'(rd_req), 32'd1);
    void'(rd_q.pop_back());
    rd_q.push_front(0);
    // the queued row 0 was already consumed by the monitor; the frame restarts its list from row 1
    rd_q.delete();
    begin
      int base;
      base = rd_done;
      for (int i = 1; i < ROWS; i++) rd_q.push_back(i);
      t = 0;
      while ((rd_done - base) < ROWS && t < 8000) begin
        @(posedge clk); #1;
        rd_used = 11'($urandom_range(300, 700));
        t++;
      end
      @(negedge clk);
      chk("frame1_frame_done", 32'(rd_frame_done), 32'd1);
      chk("frame1_rd_queue_drained", 32'(rd_q.size()), 32'd0);
    end
    @(posedge clk); #1 rd_used = 11'd0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("rd_saturated_no_req", 32'(rd_req), 32'd0);
    chk("rd_frame_done_hold", 32'(rd_frame_done), 32'd1);

    // Retrace: frame_done clears on the third edge after vsync falls
    @(posedge clk); #1 vsync = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("frame_done_before_sync", 32'(rd_frame_done), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("frame_done_cleared", 32'(rd_frame_done), 32'd0);
    repeat (20) @(posedge clk);
`ifdef SCHED_UNDERRUN_CNT_EN
    chk("underrun_full_frame", 32'(underrun_cnt), 32'd0);
`endif

    // VSYNC falls while row 5 is outstanding
    rd_limit = rd_done + 5;
    for (int i = 0; i < 6; i++) rd_q.push_back(i);
    @(posedge clk); #1 vsync = 1'b1;
    t = 0;
    while (!(rd_q.size() == 0 && rd_req) && t < 2000) begin @(negedge clk); t++; end
    chk("mid_read_reached", 32'(rd_req), 32'd1);
    @(posedge clk); #1 vsync = 1'b0;
    repeat (6) @(negedge clk);
    chk("rd_req_held_vs_low", 32'(rd_req), 32'd1);
    chk("rd_add_stable", 32'(rd_add), 32'(exp_addr(5)));
    chk("busy_in_rd_req", 32'(busy), 32'd1);
`ifdef SCHED_UNDERRUN_CNT_EN
    chk("underrun_short_frame", 32'(underrun_cnt), 32'd1);
`endif
    rd_limit = 1 << 30;
    t = 0;
    while (rd_req && t < 20) begin @(negedge clk); t++; end
    chk("rd_req_released", 32'(rd_req), 32'd0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rd_add_rewound", 32'(rd_add), 32'(exp_addr(0)));

    // Next frame restarts at row 0
    @(posedge clk); #1 vsync = 1'b1;
    read_frame("frame2");
`ifdef SCHED_UNDERRUN_CNT_EN
    @(posedge clk); #1 vsync = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("underrun_after_full", 32'(underrun_cnt), 32'd1);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
